// File: rtl/instr_q_drain.sv
// instr_q_drain: pops queue head, issues line requests to memory (flush expands to FLUSH_LINES), returns one completion
module instr_q_drain #(
  parameter int CL_SIZE = 128,
  parameter int FLUSH_LINES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_valid,
  input  logic [31:0]        q_addr,
  input  logic [2:0]         q_operation,
  input  logic               q_is_flush,
  input  logic [1:0]         q_src,
  input  logic [1:0]         q_dest,
  output logic               q_dealloc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [31:0]        mem_req_addr,
  output logic [2:0]         mem_req_op,
  output logic [1:0]         mem_req_dest,
  input  logic               mem_resp_valid,
  input  logic [CL_SIZE-1:0] mem_resp_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_src,
  output logic [31:0]        resp_addr,
  output logic               resp_is_flush,
  output logic [CL_SIZE-1:0] resp_data,
  output logic               busy
);
  localparam int OFF = $clog2(CL_SIZE / 8);
  localparam int LW = 32 - OFF;
  localparam int KW = FLUSH_LINES > 1 ? $clog2(FLUSH_LINES) : 1;
  localparam logic [KW-1:0] LAST = KW'(FLUSH_LINES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] addr;
  logic [2:0] op;
  logic flush;
  logic [1:0] src, dest;
  logic [KW-1:0] k;
  logic [CL_SIZE-1:0] data;
  logic pop, in_req, in_resp, got_resp;
  always_comb begin
    pop = state == IDLE && q_valid && !rst;
    in_req = state == REQ;
    in_resp = state == RESP;
    got_resp = state == WAIT && mem_resp_valid;
    state_nx = state == IDLE ? (q_valid ? REQ : IDLE) :
               state == REQ  ? (mem_req_ready ? WAIT : REQ) :
               state == WAIT ? (!mem_resp_valid ? WAIT : (flush && k != LAST) ? REQ : RESP) :
               (resp_ready ? IDLE : RESP);
    q_dealloc = pop;
    mem_req_valid = in_req;
    mem_req_addr = in_req ? {addr[31:OFF] + LW'(k), {OFF{1'b0}}} : '0;
    mem_req_op = in_req ? op : '0;
    mem_req_dest = in_req ? dest : '0;
    resp_valid = in_resp;
    resp_src = in_resp ? src : '0;
    resp_addr = in_resp ? addr : '0;
    resp_is_flush = in_resp && flush;
    resp_data = (in_resp && !flush) ? data : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      op <= '0;
      flush <= 1'b0;
      src <= '0;
      dest <= '0;
      k <= '0;
      data <= '0;
    end else if (pop) begin
      addr <= q_addr;
      op <= q_operation;
      flush <= q_is_flush;
      src <= q_src;
      dest <= q_dest;
      k <= '0;
      data <= '0;
    end else if (got_resp) begin
      if (flush) k <= k + 1'b1;
      else data <= mem_resp_data;
    end
  end
endmodule
